// File: rtl/if_stage.sv
// Instruction fetch stage: PC register with redirect/stall/halt control,
// asynchronously read instruction memory with a debug write port, and a
// counter of PC advances.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_FETCH | PC advances or redirects under clk_en/stall control
// ST_HALT  | HALT_WORD was fetched; PC frozen, NOP shown, reset exits
module if_stage #(
   parameter int          IMEM_DEPTH = 256,
   parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_en,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        imem_wr_en,
   input  logic [31:0] imem_wr_addr,
   input  logic [31:0] imem_wr_data,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus_4,
   output logic [31:0] if_instruction,
   output logic        halted,
   output logic [31:0] fetch_count
);

   localparam int AW = $clog2(IMEM_DEPTH);

   typedef enum logic {
      ST_FETCH = 1'b0,
      ST_HALT  = 1'b1
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [31:0]   r_pc;
   logic [31:0]   w_pc_nxt;
   logic [31:0]   r_fetch_count;
   logic          w_advance;
   logic [31:0]   r_mem [IMEM_DEPTH];
   logic [AW-1:0] w_rd_idx;
   logic [AW-1:0] w_wr_idx;
   logic [31:0]   w_raw_word;
   logic [31:0]   w_pc_plus_4;
   logic          w_unused_addr_bits;

   assign w_rd_idx    = r_pc[AW+1:2];
   assign w_wr_idx    = imem_wr_addr[AW+1:2];
   assign w_raw_word  = r_mem[w_rd_idx];
   assign w_pc_plus_4 = r_pc + 32'd4;

   // Address bits outside the word index are ignored by the write port.
   assign w_unused_addr_bits = ^{imem_wr_addr[31:AW+2], imem_wr_addr[1:0]};

   // Debug loader write port; memory is deliberately not reset so a loaded
   // program survives reset.
   always_ff @(posedge clk) begin
      if (imem_wr_en) begin
         r_mem[w_wr_idx] <= imem_wr_data;
      end
   end

   // State, PC and fetch counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_FETCH;
         r_pc          <= 32'h0;
         r_fetch_count <= 32'h0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         if (w_advance) begin
            r_fetch_count <= r_fetch_count + 32'd1;
         end
      end
   end

   // Next-PC priority: halted, !clk_en, branch, jump, stall, halt detect, PC+4.
   // A redirect beats stall (IF/ID flush wins over hold), and halt is only
   // recognised when nothing else claims the edge.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_advance   = 1'b0;
      case (r_state)
         ST_FETCH: begin
            if (!clk_en) begin
               w_pc_nxt = r_pc;
            end else if (branch_taken) begin
               w_pc_nxt  = {branch_target[31:2], 2'b00};
               w_advance = 1'b1;
            end else if (jump) begin
               w_pc_nxt  = {jump_target[31:2], 2'b00};
               w_advance = 1'b1;
            end else if (stall) begin
               w_pc_nxt = r_pc;
            end else if (w_raw_word == HALT_WORD) begin
               w_state_nxt = ST_HALT;
               w_pc_nxt    = r_pc;
            end else begin
               w_pc_nxt  = w_pc_plus_4;
               w_advance = 1'b1;
            end
         end
         ST_HALT: begin
            w_state_nxt = ST_HALT;
            w_pc_nxt    = r_pc;
         end
         default: begin
            w_state_nxt = ST_FETCH;
            w_pc_nxt    = r_pc;
         end
      endcase
   end

   assign halted         = (r_state == ST_HALT);
   assign if_pc          = r_pc;
   assign if_pc_plus_4   = w_pc_plus_4;
   assign fetch_count    = r_fetch_count;
   assign if_instruction = (reset || halted) ? 32'h0 : w_raw_word;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed fetch/redirect/halt scenarios,
// expectations queued when a step is driven and compared after the edge.
`timescale 1ns/1ps
module tb_if_stage;

   localparam logic [31:0] HALT = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clk_en = 1'b0;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic        jump = 1'b0;
   logic [31:0] jump_target = 32'h0;
   logic        imem_wr_en = 1'b0;
   logic [31:0] imem_wr_addr = 32'h0;
   logic [31:0] imem_wr_data = 32'h0;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus_4;
   logic [31:0] if_instruction;
   logic        halted;
   logic [31:0] fetch_count;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] tb_mem [256];

   string       q_tag [$];
   logic [31:0] q_pc  [$];
   logic        q_halt[$];
   logic [31:0] q_cnt [$];

   if_stage #(.IMEM_DEPTH(256), .HALT_WORD(HALT)) dut (
      .clk           (clk),
      .reset         (reset),
      .clk_en        (clk_en),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .imem_wr_en    (imem_wr_en),
      .imem_wr_addr  (imem_wr_addr),
      .imem_wr_data  (imem_wr_data),
      .if_pc         (if_pc),
      .if_pc_plus_4  (if_pc_plus_4),
      .if_instruction(if_instruction),
      .halted        (halted),
      .fetch_count   (fetch_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected fetch word for a given PC and halt flag, from the bench image.
   function automatic logic [31:0] exp_instr(input logic [31:0] pc, input logic h);
      logic [7:0] idx;
      idx = pc[9:2];
      return h ? 32'h0 : tb_mem[idx];
   endfunction

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      logic [7:0] idx;
      @(negedge clk);
      imem_wr_en   = 1'b1;
      imem_wr_addr = addr;
      imem_wr_data = data;
      @(posedge clk);
      #1;
      imem_wr_en = 1'b0;
      idx = addr[9:2];
      tb_mem[idx] = data;
   endtask

   // One clock step: drive controls, queue the expectation, compare after edge.
   task automatic cyc(input string tag, input logic en, input logic st,
                      input logic br, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt,
                      input logic [31:0] e_pc, input logic e_halt, input logic [31:0] e_cnt);
      string       t;
      logic [31:0] p;
      logic        h;
      logic [31:0] c;
      @(negedge clk);
      clk_en        = en;
      stall         = st;
      branch_taken  = br;
      branch_target = bt;
      jump          = j;
      jump_target   = jt;
      q_tag.push_back(tag);
      q_pc.push_back(e_pc);
      q_halt.push_back(e_halt);
      q_cnt.push_back(e_cnt);
      @(posedge clk);
      #1;
      clk_en       = 1'b0;
      stall        = 1'b0;
      branch_taken = 1'b0;
      jump         = 1'b0;
      if (q_tag.size() == 0) begin
         chk({tag, "_queue"}, 32'd0, 32'd1);
      end else begin
         t = q_tag.pop_front();
         p = q_pc.pop_front();
         h = q_halt.pop_front();
         c = q_cnt.pop_front();
         chk({t, "_pc"},    if_pc,             p);
         chk({t, "_pc4"},   if_pc_plus_4,      p + 32'd4);
         chk({t, "_halt"},  {31'd0, halted},   {31'd0, h});
         chk({t, "_cnt"},   fetch_count,       c);
         chk({t, "_instr"}, if_instruction,    exp_instr(p, h));
      end
   endtask

   task automatic pulse_reset(input string tag);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk({tag, "_pc"},    if_pc,            32'h0);
      chk({tag, "_pc4"},   if_pc_plus_4,     32'h4);
      chk({tag, "_halt"},  {31'd0, halted},  32'h0);
      chk({tag, "_cnt"},   fetch_count,      32'h0);
      chk({tag, "_instr"}, if_instruction,   32'h0);
      @(negedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state with memory still unloaded.
      #3;
      chk("rst_pc",    if_pc,           32'h0);
      chk("rst_pc4",   if_pc_plus_4,    32'h4);
      chk("rst_halt",  {31'd0, halted}, 32'h0);
      chk("rst_cnt",   fetch_count,     32'h0);
      chk("rst_instr", if_instruction,  32'h0);
      @(negedge clk);
      reset = 1'b0;

      // Load the whole memory with clk_en low; PC must not move.
      for (int k = 0; k < 256; k++) begin
         logic [7:0] kb;
         kb = k[7:0];
         wr({22'd0, kb, 2'b00}, {16'hA5A5, 8'h00, kb});
      end
      chk("load_pc",  if_pc,       32'h0);
      chk("load_cnt", fetch_count, 32'h0);

      // Program survives a mid-cycle reset.
      pulse_reset("rst2");
      #1;
      chk("survive_instr", if_instruction, 32'hA5A5_0000);

      // Sequential fetch.
      cyc("seq1", 1, 0, 0, 0, 0, 0, 32'h04, 0, 1);
      cyc("seq2", 1, 0, 0, 0, 0, 0, 32'h08, 0, 2);
      cyc("seq3", 1, 0, 0, 0, 0, 0, 32'h0C, 0, 3);

      // Stall holds; redirect beats stall and clears low address bits.
      cyc("stall1", 1, 1, 0, 0, 0, 0, 32'h0C, 0, 3);
      cyc("stall2", 1, 1, 0, 0, 0, 0, 32'h0C, 0, 3);
      cyc("stbr",   1, 1, 1, 32'h23, 0, 0, 32'h20, 0, 4);

      // Redirect priority and clk_en gating.
      cyc("brjmp",  1, 0, 1, 32'h40, 1, 32'h80, 32'h40, 0, 5);
      cyc("jmp",    1, 0, 0, 0, 1, 32'h80, 32'h80, 0, 6);
      cyc("noen",   0, 0, 1, 32'h40, 0, 0, 32'h80, 0, 6);

      // Address wrap in memory and 32-bit PC wrap.
      cyc("j3fc",   1, 0, 0, 0, 1, 32'h3FF, 32'h3FC, 0, 7);
      cyc("w400",   1, 0, 0, 0, 0, 0, 32'h400, 0, 8);
      cyc("jtop",   1, 0, 0, 0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 0, 9);
      cyc("wrap0",  1, 0, 0, 0, 0, 0, 32'h0, 0, 10);

      // Write to the word under the PC: old word this cycle, new after edge.
      @(negedge clk);
      imem_wr_en   = 1'b1;
      imem_wr_addr = 32'h0;
      imem_wr_data = 32'hDEAD_BEEF;
      #1;
      chk("wrpc_old", if_instruction, 32'hA5A5_0000);
      @(posedge clk);
      #1;
      imem_wr_en = 1'b0;
      tb_mem[0]  = 32'hDEAD_BEEF;
      chk("wrpc_new", if_instruction, 32'hDEAD_BEEF);

      // Halt: blocked by stall and by a same-cycle redirect, then taken.
      wr(32'h0C, HALT);
      cyc("h_s1",   1, 0, 0, 0, 0, 0, 32'h04, 0, 11);
      cyc("h_s2",   1, 0, 0, 0, 0, 0, 32'h08, 0, 12);
      cyc("h_s3",   1, 0, 0, 0, 0, 0, 32'h0C, 0, 13);
      cyc("h_stall",1, 1, 0, 0, 0, 0, 32'h0C, 0, 13);
      cyc("h_redir",1, 0, 1, 32'h0C, 0, 0, 32'h0C, 0, 14);
      cyc("h_take", 1, 0, 0, 0, 0, 0, 32'h0C, 1, 14);
      cyc("h_hold", 1, 0, 1, 32'h40, 0, 0, 32'h0C, 1, 14);

      // Memory writes still land while halted.
      wr(32'h10, 32'h1234_5678);
      chk("h_wr_halt",  {31'd0, halted}, 32'h1);
      chk("h_wr_instr", if_instruction,  32'h0);

      // Reset out of halt resumes from PC 0.
      pulse_reset("rst3");
      cyc("post1",  1, 0, 0, 0, 0, 0, 32'h04, 0, 1);
      cyc("post2",  1, 0, 0, 0, 1, 32'h10, 32'h10, 0, 2);

      if (q_tag.size() != 0) begin
         chk("queue_empty", q_tag.size(), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
